// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters with registered sync decode.
// Positions and decoded flags all change together on the pixel tick edge.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_en,
  output logic [9:0] xcount,
  output logic [9:0] ycount,
  output logic       indisplay,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  localparam logic [9:0] HMAX =
    10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VMAX =
    10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic          tick;
  logic          xwrap;
  logic [9:0]    xnext;
  logic [9:0]    ynext;

  always_comb begin
    tick  = (div == DIV_MAX);
    xwrap = (xcount == HMAX);
    xnext = xwrap ? 10'd0 : xcount + 10'd1;
    ynext = ycount;
    if (xwrap) begin
      ynext = (ycount == VMAX) ? 10'd0 : ycount + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
    end
  end

  // Decode the next position so flags line up with the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xcount      <= HMAX;
      ycount      <= VMAX;
      indisplay   <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      pixel_en    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_en    <= tick;
      frame_start <= tick && (xnext == 10'd0) && (ynext == 10'd0);
      if (tick) begin
        xcount    <= xnext;
        ycount    <= ynext;
        indisplay <= (xnext < HA) && (ynext < VA);
        hsync     <= !((xnext >= HS0) && (xnext < HS1));
        vsync     <= !((ynext >= VS0) && (ynext < VS1));
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three builds (default, CLK_DIV=1, tiny raster)
// checked against a closed-form position model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edges;

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  logic       pe0, fs0, ind0, hs0, vs0;
  logic [9:0] x0, y0;
  logic       pe1, fs1, ind1, hs1, vs1;
  logic [9:0] x1, y1;
  logic       pe2, fs2, ind2, hs2, vs2;
  logic [9:0] x2, y2;

  vga_timing_gen u0 (
    .clk(clk), .reset(reset), .pixel_en(pe0),
    .xcount(x0), .ycount(y0), .indisplay(ind0),
    .hsync(hs0), .vsync(vs0), .frame_start(fs0)
  );

  vga_timing_gen #(.CLK_DIV(1)) u1 (
    .clk(clk), .reset(reset), .pixel_en(pe1),
    .xcount(x1), .ycount(y1), .indisplay(ind1),
    .hsync(hs1), .vsync(vs1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .CLK_DIV(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u2 (
    .clk(clk), .reset(reset), .pixel_en(pe2),
    .xcount(x2), .ycount(y2), .indisplay(ind2),
    .hsync(hs2), .vsync(vs2), .frame_start(fs2)
  );

  logic [24:0] p0, p1, p2;
  assign p0 = {x0, y0, ind0, hs0, vs0, pe0, fs0};
  assign p1 = {x1, y1, ind1, hs1, vs1, pe1, fs1};
  assign p2 = {x2, y2, ind2, hs2, vs2, pe2, fs2};

  // Expected outputs after `e` clock edges since reset release.
  function automatic logic [24:0] model(
    input int e, input int d,
    input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb
  );
    int ht, vt, ticks, p, x, y;
    logic pe, fs, ind, hsy, vsy;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    ticks = e / d;
    if (ticks == 0) begin
      return {10'(ht - 1), 10'(vt - 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    end
    p   = (ticks - 1) % (ht * vt);
    x   = p % ht;
    y   = p / ht;
    pe  = (e % d) == 0;
    fs  = pe && (p == 0);
    ind = (x < ha) && (y < va);
    hsy = !((x >= ha + hf) && (x < ha + hf + hs));
    vsy = !((y >= va + vf) && (y < va + vf + vs));
    return {10'(x), 10'(y), ind, hsy, vsy, pe, fs};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] r0, r2, first, after;
    r0    = {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    r2    = {10'd14, 10'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    first = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    after = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    repeat ($urandom_range(20, 200)) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks += 3;
    if (p0 !== r0) begin
      errors++;
      $display("FAIL reset_async_u0 got %h want %h", p0, r0);
    end
    if (p1 !== r0) begin
      errors++;
      $display("FAIL reset_async_u1 got %h want %h", p1, r0);
    end
    if (p2 !== r2) begin
      errors++;
      $display("FAIL reset_async_u2 got %h want %h", p2, r2);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (p0 !== r0) begin
      errors++;
      $display("FAIL reset_hold_e2 got %h want %h", p0, r0);
    end
    @(negedge clk);
    checks++;
    if (p0 !== first) begin
      errors++;
      $display("FAIL reset_first_tick got %h want %h", p0, first);
    end
    @(negedge clk);
    checks++;
    if (p0 !== after) begin
      errors++;
      $display("FAIL reset_pulse_fall got %h want %h", p0, after);
    end
  endtask

  task automatic test_horizontal();
    int fall_x = -1, fall_px = -1, hsf = -1, hsr = -1, wy = -1;
    logic wfs = 1'bx;
    logic [9:0] px;
    logic pind, phs;
    do_reset();
    px = x0; pind = ind0; phs = hs0;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      if (pind && !ind0 && fall_x < 0) begin
        fall_x = int'(x0);
        fall_px = int'(px);
      end
      if (phs && !hs0 && hsf < 0) hsf = int'(x0);
      if (!phs && hs0 && hsr < 0) hsr = int'(x0);
      if (px == 10'd799 && x0 == 10'd0 && y0 != 10'd0 && wy < 0) begin
        wy = int'(y0);
        wfs = fs0;
      end
      px = x0; pind = ind0; phs = hs0;
    end
    checks += 6;
    if (fall_px != 639) begin
      errors++;
      $display("FAIL h_ind_prev_x got %0d want 639", fall_px);
    end
    if (fall_x != 640) begin
      errors++;
      $display("FAIL h_ind_fall_x got %0d want 640", fall_x);
    end
    if (hsf != 656) begin
      errors++;
      $display("FAIL h_sync_fall got %0d want 656", hsf);
    end
    if (hsr != 752) begin
      errors++;
      $display("FAIL h_sync_rise got %0d want 752", hsr);
    end
    if (wy != 1) begin
      errors++;
      $display("FAIL h_wrap_y got %0d want 1", wy);
    end
    if (wfs !== 1'b0) begin
      errors++;
      $display("FAIL h_wrap_fs got %b want 0", wfs);
    end
  endtask

  task automatic test_vertical();
    logic [15:0] vl = '0, il = '0, ic = '0, hc = '0;
    do_reset();
    for (int i = 0; i < 340; i++) begin
      @(negedge clk);
      if (!vs2) vl[y2[3:0]] = 1'b1;
      if (!hs2) hc[x2[3:0]] = 1'b1;
      if (ind2) begin
        il[y2[3:0]] = 1'b1;
        ic[x2[3:0]] = 1'b1;
      end
    end
    checks += 4;
    if (vl !== 16'h00C0) begin
      errors++;
      $display("FAIL v_sync_lines got %h want 00c0", vl);
    end
    if (il !== 16'h001F) begin
      errors++;
      $display("FAIL v_active_lines got %h want 001f", il);
    end
    if (ic !== 16'h00FF) begin
      errors++;
      $display("FAIL v_active_cols got %h want 00ff", ic);
    end
    if (hc !== 16'h1C00) begin
      errors++;
      $display("FAIL v_hsync_cols got %h want 1c00", hc);
    end
  endtask

  task automatic test_frame_wrap();
    int t1 = -1, t2 = -1, nfs = 0, wbad = 0, pw = 0, per;
    logic [9:0] px, py;
    logic pfs;
    do_reset();
    px = x2; py = y2; pfs = fs2;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (fs2) begin
        nfs++;
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
        if (pfs) pw++;
        if (px != 10'd14 || py != 10'd9 || x2 != 10'd0 || y2 != 10'd0)
          wbad++;
      end
      px = x2; py = y2; pfs = fs2;
    end
    per = (t1 >= 0 && t2 >= 0) ? t2 - t1 : -1;
    checks += 5;
    if (t1 != 1) begin
      errors++;
      $display("FAIL f_first_tick got %0d want 1", t1);
    end
    if (per != 300) begin
      errors++;
      $display("FAIL f_period got %0d want 300", per);
    end
    if (nfs != 3) begin
      errors++;
      $display("FAIL f_count got %0d want 3", nfs);
    end
    if (pw != 0) begin
      errors++;
      $display("FAIL f_width got %0d want 0", pw);
    end
    if (wbad != 0) begin
      errors++;
      $display("FAIL f_wrap_pos got %0d want 0", wbad);
    end
  endtask

  task automatic test_cadence();
    int np = 0, bad = 0, badint = 0, last = -1;
    logic [19:0] pxy;
    logic ppe;
    do_reset();
    repeat (20) @(negedge clk);
    pxy = {x0, y0}; ppe = pe0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pe0) begin
        np++;
        if (ppe) bad++;
        if (last >= 0 && i - last != 4) badint++;
        last = i;
      end
      if ({x0, y0} != pxy && !pe0) bad++;
      pxy = {x0, y0}; ppe = pe0;
    end
    checks += 3;
    if (np != 100) begin
      errors++;
      $display("FAIL c_pulses got %0d want 100", np);
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL c_untimed got %0d want 0", bad);
    end
    if (badint != 0) begin
      errors++;
      $display("FAIL c_interval got %0d want 0", badint);
    end
  endtask

  task automatic test_clkdiv1();
    int pelow = 0, z1 = -1, z2 = -1, hsf = -1, hsr = -1, per;
    logic phs;
    do_reset();
    phs = hs1;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      if (!pe1) pelow++;
      if (x1 == 10'd0) begin
        if (z1 < 0) z1 = i;
        else if (z2 < 0) z2 = i;
      end
      if (phs && !hs1 && hsf < 0) hsf = int'(x1);
      if (!phs && hs1 && hsr < 0) hsr = int'(x1);
      phs = hs1;
    end
    per = (z1 >= 0 && z2 >= 0) ? z2 - z1 : -1;
    checks += 5;
    if (pelow != 0) begin
      errors++;
      $display("FAIL d1_pe_low got %0d want 0", pelow);
    end
    if (z1 != 0) begin
      errors++;
      $display("FAIL d1_first got %0d want 0", z1);
    end
    if (per != 800) begin
      errors++;
      $display("FAIL d1_line got %0d want 800", per);
    end
    if (hsf != 656) begin
      errors++;
      $display("FAIL d1_hs_fall got %0d want 656", hsf);
    end
    if (hsr != 752) begin
      errors++;
      $display("FAIL d1_hs_rise got %0d want 752", hsr);
    end
  endtask

  task automatic test_random_model();
    logic [24:0] w0, w1, w2;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      repeat ($urandom_range(300, 1500)) begin
        @(negedge clk);
        w0 = model(edges, 4, 640, 16, 96, 48, 480, 10, 2, 33);
        w1 = model(edges, 1, 640, 16, 96, 48, 480, 10, 2, 33);
        w2 = model(edges, 2, 8, 2, 3, 2, 5, 1, 2, 2);
        checks += 3;
        if (p0 !== w0) begin
          errors++;
          $display("FAIL rand_u0 e=%0d got %h want %h", edges, p0, w0);
        end
        if (p1 !== w1) begin
          errors++;
          $display("FAIL rand_u1 e=%0d got %h want %h", edges, p1, w1);
        end
        if (p2 !== w2) begin
          errors++;
          $display("FAIL rand_u2 e=%0d got %h want %h", edges, p2, w2);
        end
      end
      @(posedge clk);
      #($urandom_range(1, 4)) reset = 1'b1;
      #1;
      w0 = model(edges, 4, 640, 16, 96, 48, 480, 10, 2, 33);
      w2 = model(edges, 2, 8, 2, 3, 2, 5, 1, 2, 2);
      checks += 2;
      if (p0 !== w0) begin
        errors++;
        $display("FAIL rand_rst_u0 got %h want %h", p0, w0);
      end
      if (p2 !== w2) begin
        errors++;
        $display("FAIL rand_rst_u2 got %h want %h", p2, w2);
      end
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_frame_wrap();
    test_cadence();
    test_clkdiv1();
    test_random_model();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
